// File: rtl/maxpool2x2.sv
// Streaming 2x2 stride-2 max-pool over a raster of signed samples, with optional
// ReLU clamp ahead of the compare and a one-deep elastic output register.
module maxpool2x2 #(
  parameter int LineWidthPx = 158,
  parameter int LineCountPx = 118,
  parameter int Width       = 32,
  parameter bit ReluEn      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             last_o
);

  localparam int HalfW = LineWidthPx / 2;
  localparam int HalfH = LineCountPx / 2;
  localparam int XW    = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
  localparam int YW    = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
  localparam int IW    = (HalfW > 1) ? $clog2(HalfW) : 1;

  // Handshake: a sample transfers on a rising edge where valid_i & ready_o; a pooled
  // result transfers where valid_o & ready_i. valid_o never drops and data_o/last_o never
  // change while a result waits for ready_i.
  logic in_fire;

  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic [XW-1:0] x_half;
  logic [YW-1:0] y_half;
  logic [IW-1:0] col;
  logic          x_last;
  logic          y_last;
  logic          x_used;
  logic          y_used;

  logic signed [Width-1:0] din;
  logic signed [Width-1:0] s;
  logic signed [Width-1:0] h_max;
  logic signed [Width-1:0] pair_max;
  logic signed [Width-1:0] line_rd;
  logic signed [Width-1:0] quad_max;
  logic signed [Width-1:0] linebuf [HalfW];

  logic produce;
  logic line_wr;
  logic last_next;

  assign ready_o = ~valid_o | ready_i;
  assign in_fire = valid_i & ready_o;

  assign x_half = x_pos >> 1;
  assign y_half = y_pos >> 1;
  assign col    = x_half[IW-1:0];
  assign x_last = (x_pos == XW'(LineWidthPx - 1));
  assign y_last = (y_pos == YW'(LineCountPx - 1));

  // Only an odd dimension leaves a trailing column/row outside every 2x2 window.
  assign x_used = ((LineWidthPx % 2) == 0) || !x_last;
  assign y_used = ((LineCountPx % 2) == 0) || !y_last;

  assign din = $signed(data_i);

  always_comb begin
    s = din;
    if (ReluEn && din[Width-1]) begin
      s = '0;
    end
  end

  always_comb begin
    pair_max = (s > h_max) ? s : h_max;
    line_rd  = linebuf[col];
    quad_max = (line_rd > pair_max) ? line_rd : pair_max;
  end

  assign line_wr   = in_fire && x_pos[0] && !y_pos[0] && y_used;
  assign produce   = in_fire && x_pos[0] && y_pos[0];
  assign last_next = (x_half == XW'(HalfW - 1)) && (y_half == YW'(HalfH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (in_fire) begin
      if (x_last) begin
        x_pos <= '0;
        y_pos <= y_last ? '0 : y_pos + 1'b1;
      end else begin
        x_pos <= x_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_max <= '0;
    end else if (in_fire && !x_pos[0] && x_used) begin
      h_max <= s;
    end
  end

  // Even rows write, odd rows read the same column, so contents never need a reset.
  always_ff @(posedge clk_i) begin
    if (line_wr) begin
      linebuf[col] <= pair_max;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (produce) begin
      valid_o <= 1'b1;
      data_o  <= quad_max;
      last_o  <= last_next;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
